// File: rtl/attribute_store_pkg.sv
// Shared constants for the attribute store: field widths, slot count,
// attribute type codes and the element-collection FSM states.
package attribute_store_pkg;

  localparam int ATTRIBUTE_TYPE_BITS = 4;
  localparam int ATTRIBUTE_VAL_BITS  = 16;
  localparam int NUM_ATTRIBUTES      = 11;

  // Type code k lands in slot k-1; code 0 is reserved as "no attribute".
  localparam int ATTR_COLOR    = 1;
  localparam int ATTR_SIZE     = 2;
  localparam int ATTR_WIDTH    = 3;
  localparam int ATTR_HEIGHT   = 4;
  localparam int ATTR_SRC      = 5;
  localparam int ATTR_HREF     = 6;
  localparam int ATTR_BG       = 7;
  localparam int ATTR_PADDING  = 8;
  localparam int ATTR_MARGIN   = 9;
  localparam int ATTR_BORDER   = 10;
  localparam int ATTR_POSITION = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESTART = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  function automatic logic is_known(input int code, input int num);
    return (code >= 1) && (code <= num);
  endfunction

endpackage

// File: rtl/attribute_store_edge_detect.sv
// Rising-edge pulse generator for the attribute parser's has_finished level.
module attr_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/attribute_store.sv
// Collects typed attributes for one element into a shadow set and publishes
// the whole set atomically when the element closes.
module attribute_store
  import attribute_store_pkg::*;
#(
  parameter int TYPE_W  = ATTRIBUTE_TYPE_BITS,
  parameter int VAL_W   = ATTRIBUTE_VAL_BITS,
  parameter int NUM_ATT = NUM_ATTRIBUTES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     element_start,
  input  logic                     element_end,
  input  logic                     attr_done,
  input  logic [TYPE_W-1:0]        in_type,
  input  logic [VAL_W-1:0]         in_value,
  output logic                     attr_restart,
  output logic [NUM_ATT*VAL_W-1:0] out_style,
  output logic [NUM_ATT-1:0]       out_present,
  output logic                     style_valid,
  output logic [3:0]               attr_count,
  output logic                     err_unknown,
  output logic                     busy
);

  state_t                   state, state_next;
  logic [NUM_ATT*VAL_W-1:0] shadow;
  logic [NUM_ATT-1:0]       mask;
  logic                     pending_end;
  logic                     done_rise;
  logic                     clear_elem;
  logic                     capture;
  logic                     set_pending;
  logic                     known;

  attr_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .level (attr_done),
    .rise  (done_rise)
  );

  assign known = is_known(int'(in_type), NUM_ATT);
  assign busy  = (state != ST_IDLE);

  always_comb begin
    state_next   = state;
    attr_restart = 1'b0;
    style_valid  = 1'b0;
    clear_elem   = 1'b0;
    capture      = 1'b0;
    set_pending  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (element_start) begin
          clear_elem = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (element_start) begin
          clear_elem = 1'b1;
          state_next = ST_COLLECT;
        end else if (done_rise) begin
          capture     = 1'b1;
          set_pending = element_end;
          state_next  = ST_RESTART;
        end else if (element_end) begin
          state_next = ST_COMMIT;
        end
      end
      ST_RESTART: begin
        attr_restart = 1'b1;
        if (element_start) begin
          clear_elem = 1'b1;
          state_next = ST_COLLECT;
        end else if (pending_end || element_end) begin
          state_next = ST_COMMIT;
        end else begin
          state_next = ST_COLLECT;
        end
      end
      ST_COMMIT: begin
        style_valid = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Published outputs load on the edge entering COMMIT so they are already
  // stable during the style_valid cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      mask        <= '0;
      attr_count  <= 4'd0;
      err_unknown <= 1'b0;
      pending_end <= 1'b0;
      out_style   <= '0;
      out_present <= '0;
    end else begin
      state <= state_next;
      if (clear_elem) begin
        shadow      <= '0;
        mask        <= '0;
        attr_count  <= 4'd0;
        err_unknown <= 1'b0;
        pending_end <= 1'b0;
      end else if (capture) begin
        if (known) begin
          for (int k = 0; k < NUM_ATT; k++) begin
            if (in_type == TYPE_W'(k + 1)) begin
              shadow[k*VAL_W +: VAL_W] <= in_value;
              mask[k]                  <= 1'b1;
            end
          end
          if (attr_count != 4'hF) attr_count <= attr_count + 4'd1;
        end else begin
          err_unknown <= 1'b1;
        end
        if (set_pending) pending_end <= 1'b1;
      end
      if (state_next == ST_COMMIT) begin
        out_style   <= shadow;
        out_present <= mask;
        pending_end <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attribute_store.sv
// Directed bench for attribute_store: element lifecycle, capture edge rules,
// pending end, abort, reset and count saturation.
module tb_attribute_store;
  import attribute_store_pkg::*;

  localparam int TW = 4;
  localparam int VW = 16;
  localparam int NA = 11;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             element_start = 1'b0;
  logic             element_end = 1'b0;
  logic             attr_done = 1'b0;
  logic [TW-1:0]    in_type = '0;
  logic [VW-1:0]    in_value = '0;
  logic             attr_restart;
  logic [NA*VW-1:0] out_style;
  logic [NA-1:0]    out_present;
  logic             style_valid;
  logic [3:0]       attr_count;
  logic             err_unknown;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  attribute_store #(.TYPE_W(TW), .VAL_W(VW), .NUM_ATT(NA)) dut (
    .clock         (clock),
    .reset         (reset),
    .element_start (element_start),
    .element_end   (element_end),
    .attr_done     (attr_done),
    .in_type       (in_type),
    .in_value      (in_value),
    .attr_restart  (attr_restart),
    .out_style     (out_style),
    .out_present   (out_present),
    .style_valid   (style_valid),
    .attr_count    (attr_count),
    .err_unknown   (err_unknown),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [VW-1:0] slot(input int k);
    return out_style[k*VW +: VW];
  endfunction

  task automatic start_elem();
    element_start = 1'b1;
    tick();
    element_start = 1'b0;
  endtask

  task automatic end_elem();
    element_end = 1'b1;
    tick();
    element_end = 1'b0;
  endtask

  // One attribute: rise of attr_done, then drop it during the RESTART cycle.
  task automatic capture(input int t, input logic [VW-1:0] v);
    attr_done = 1'b1;
    in_type   = TW'(t);
    in_value  = v;
    tick();
    attr_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (out_style !== '0) begin n_fail++; $display("FAIL reset_style got %h want 0", out_style); end
    n_checks++;
    if (out_present !== '0) begin n_fail++; $display("FAIL reset_present got %h want 0", out_present); end
    n_checks++;
    if ({style_valid, attr_restart, err_unknown, attr_count} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0", {style_valid, attr_restart, err_unknown, attr_count});
    end
  endtask

  task automatic test_basic();
    start_elem();
    attr_done = 1'b1;
    in_type   = TW'(ATTR_WIDTH);
    in_value  = 16'd120;
    tick();
    n_checks++;
    if (attr_restart !== 1'b1) begin n_fail++; $display("FAIL basic_restart got %b want 1", attr_restart); end
    n_checks++;
    if (attr_count !== 4'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", attr_count); end
    attr_done = 1'b0;
    tick();
    n_checks++;
    if (attr_restart !== 1'b0) begin n_fail++; $display("FAIL basic_restart_len got %b want 0", attr_restart); end
    end_elem();
    n_checks++;
    if (style_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", style_valid); end
    n_checks++;
    if (slot(2) !== 16'd120) begin n_fail++; $display("FAIL basic_slot2 got %0d want 120", slot(2)); end
    n_checks++;
    if (out_present !== 11'h004) begin n_fail++; $display("FAIL basic_present got %h want 004", out_present); end
    tick();
    n_checks++;
    if ({style_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_idle got %b want 00", {style_valid, busy}); end
  endtask

  task automatic test_level_high();
    int restarts = 0;
    start_elem();
    attr_done = 1'b1;
    in_type   = TW'(ATTR_COLOR);
    in_value  = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (attr_restart === 1'b1) restarts++;
    end
    attr_done = 1'b0;
    n_checks++;
    if (restarts != 1) begin n_fail++; $display("FAIL level_restarts got %0d want 1", restarts); end
    n_checks++;
    if (attr_count !== 4'd1) begin n_fail++; $display("FAIL level_count got %0d want 1", attr_count); end
    end_elem();
    n_checks++;
    if (slot(0) !== 16'h0F00 || out_present !== 11'h001) begin
      n_fail++; $display("FAIL level_commit got %h/%h want 0f00/001", slot(0), out_present);
    end
    tick();
  endtask

  task automatic test_duplicate_unknown();
    start_elem();
    capture(ATTR_WIDTH, 16'd10);
    capture(ATTR_WIDTH, 16'd20);
    n_checks++;
    if (attr_count !== 4'd2 || err_unknown !== 1'b0) begin
      n_fail++; $display("FAIL dup_count got %0d/%b want 2/0", attr_count, err_unknown);
    end
    capture(12, 16'hDEAD);
    n_checks++;
    if (attr_count !== 4'd2 || err_unknown !== 1'b1) begin
      n_fail++; $display("FAIL unknown12 got %0d/%b want 2/1", attr_count, err_unknown);
    end
    capture(0, 16'hBEEF);
    n_checks++;
    if (attr_count !== 4'd2 || err_unknown !== 1'b1) begin
      n_fail++; $display("FAIL unknown0 got %0d/%b want 2/1", attr_count, err_unknown);
    end
    end_elem();
    n_checks++;
    if (slot(2) !== 16'd20 || out_present !== 11'h004) begin
      n_fail++; $display("FAIL dup_commit got %0d/%h want 20/004", slot(2), out_present);
    end
    tick();
  endtask

  task automatic test_coincident_end();
    start_elem();
    attr_done   = 1'b1;
    element_end = 1'b1;
    in_type     = TW'(ATTR_PADDING);
    in_value    = 16'd4;
    tick();
    attr_done   = 1'b0;
    element_end = 1'b0;
    n_checks++;
    if (style_valid !== 1'b0 || attr_restart !== 1'b1) begin
      n_fail++; $display("FAIL coinc_first got %b/%b want 0/1", style_valid, attr_restart);
    end
    tick();
    n_checks++;
    if (style_valid !== 1'b1) begin n_fail++; $display("FAIL coinc_valid got %b want 1", style_valid); end
    n_checks++;
    if (slot(7) !== 16'd4 || out_present !== 11'h080) begin
      n_fail++; $display("FAIL coinc_commit got %0d/%h want 4/080", slot(7), out_present);
    end
    tick();
  endtask

  task automatic test_abort_and_reset();
    start_elem();
    capture(ATTR_HEIGHT, 16'd50);
    start_elem();
    n_checks++;
    if (style_valid !== 1'b0 || attr_count !== 4'd0 || out_present !== 11'h080) begin
      n_fail++; $display("FAIL abort_state got %b/%0d/%h want 0/0/080", style_valid, attr_count, out_present);
    end
    end_elem();
    n_checks++;
    if (slot(3) !== 16'd0 || out_present !== 11'h000 || style_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_commit got %0d/%h/%b want 0/000/1", slot(3), out_present, style_valid);
    end
    tick();
    start_elem();
    element_start = 1'b1;
    element_end   = 1'b1;
    tick();
    element_start = 1'b0;
    element_end   = 1'b0;
    n_checks++;
    if (style_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_wins got %b/%b want 0/1", style_valid, busy);
    end
    capture(ATTR_COLOR, 16'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_style !== '0 || out_present !== '0 || attr_count !== 4'd0) begin
      n_fail++; $display("FAIL midreset got busy=%b present=%h count=%0d want 0/000/0", busy, out_present, attr_count);
    end
  endtask

  task automatic test_boundary_saturate();
    start_elem();
    capture(ATTR_POSITION, 16'hBEEF);
    capture(ATTR_COLOR, 16'h1234);
    end_elem();
    n_checks++;
    if (slot(10) !== 16'hBEEF || slot(0) !== 16'h1234 || out_present !== 11'h401) begin
      n_fail++; $display("FAIL bounds got %h/%h/%h want beef/1234/401", slot(10), slot(0), out_present);
    end
    tick();
    start_elem();
    for (int i = 0; i < 15; i++) capture(ATTR_SIZE, 16'(i));
    n_checks++;
    if (attr_count !== 4'd15) begin n_fail++; $display("FAIL count15 got %0d want 15", attr_count); end
    capture(ATTR_SIZE, 16'd99);
    n_checks++;
    if (attr_count !== 4'd15) begin n_fail++; $display("FAIL count_sat got %0d want 15", attr_count); end
    end_elem();
    n_checks++;
    if (slot(1) !== 16'd99 || out_present !== 11'h002) begin
      n_fail++; $display("FAIL sat_commit got %0d/%h want 99/002", slot(1), out_present);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_high();
    test_duplicate_unknown();
    test_coincident_end();
    test_abort_and_reset();
    test_boundary_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
